// File: rtl/ab_sequence_fsm_pkg.sv
// ab_sequence_fsm_pkg: state encoding and symbol constants shared by the sequence detector.
package ab_sequence_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        DET  = 2'd3
    } state_t;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/ab_sequence_fsm_hold_timer.sv
// hold_timer: loadable down-counter that flags when it has reached zero.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears the count
//   load     load load_val (takes priority over en)
//   load_val value loaded on load
//   en       decrement by one
//   zero     high while the count is zero
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ab_sequence_fsm.sv
// ab_sequence_fsm: Moore detector for symbol sequence 01 -> 10 -> 11 on {A,B}, holding Out for HOLD_CYCLES cycles.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, forces IDLE and Out=0 at once
//   A    symbol bit 1 (MSB)
//   B    symbol bit 0 (LSB)
//   Out  registered detection flag, high exactly while in DET
module ab_sequence_fsm
    import ab_sequence_fsm_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    output logic Out
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    state_t     state, state_next;
    logic [1:0] sym;
    logic       load, en, zero, out_d;

    assign sym = {A, B};

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (LOAD_VAL),
        .en       (en),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A 01 always restarts the match; this is the only overlap recovery.
    always_comb begin
        state_next = IDLE;
        load       = 1'b0;
        en         = 1'b0;
        case (state)
            IDLE: state_next = (sym == SYM_01) ? S1 : IDLE;
            S1:   state_next = (sym == SYM_10) ? S2 : (sym == SYM_01) ? S1 : IDLE;
            S2: begin
                state_next = (sym == SYM_11) ? DET : (sym == SYM_01) ? S1 : IDLE;
                load       = (sym == SYM_11);
            end
            // Symbols are ignored while holding; the exit edge still honours a 01.
            DET: begin
                state_next = !zero ? DET : (sym == SYM_01) ? S1 : IDLE;
                en         = !zero;
            end
            default: state_next = IDLE;
        endcase
    end

    // Out is registered from the next state so it equals (state == DET) without a decode after the flop.
    always_comb out_d = (state_next == DET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Out <= 1'b0;
        else
            Out <= out_d;
    end

endmodule

// File: tb/tb_ab_sequence_fsm.sv
// tb_ab_sequence_fsm: directed self-checking bench for ab_sequence_fsm with HOLD_CYCLES = 1, 2 and 5.
module tb_ab_sequence_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0;
    logic B = 1'b0;
    logic out1, out2, out5;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ab_sequence_fsm #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .A(A), .B(B), .Out(out1));
    ab_sequence_fsm #(.HOLD_CYCLES(2), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .A(A), .B(B), .Out(out2));
    ab_sequence_fsm #(.HOLD_CYCLES(5), .CNT_W(4)) dut5 (.clk(clk), .rst(rst), .A(A), .B(B), .Out(out5));

    // Drive a symbol at the falling edge, then return 1 time unit after the rising edge that samples it.
    task automatic step(input logic [1:0] s);
        @(negedge clk);
        {A, B} = s;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {A, B} = 2'($urandom_range(3));
            @(posedge clk);
            #1;
            tests++;
            if (out2 !== 1'b0) begin
                fails++;
                $display("FAIL reset_held[%0d] out=%b exp=0", i, out2);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(2'b00);
            tests++;
            if (out2 !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle[%0d] out=%b exp=0", i, out2);
            end
        end
        // Only reachable from S1 if reset did not leave IDLE.
        step(2'b10);
        step(2'b11);
        tests++;
        if (out2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state out=%b exp=0", out2);
        end
    endtask

    task automatic test_basic();
        logic [9:0] syms = 10'b01_10_11_00_00;
        logic [4:0] exp  = 5'b00110;
        for (int i = 0; i < 5; i++) begin
            step(syms[2*(4-i) +: 2]);
            tests++;
            if (out2 !== exp[4-i]) begin
                fails++;
                $display("FAIL basic[%0d] out=%b exp=%b", i, out2, exp[4-i]);
            end
        end
    endtask

    task automatic test_near_miss();
        logic [35:0] syms = 36'b01_10_10_11_00_01_11_00_10_11_00_01_01_10_11_00_00_00;
        logic [17:0] exp  = 18'b0000_00_000_00000_1100;
        for (int i = 0; i < 18; i++) begin
            step(syms[2*(17-i) +: 2]);
            tests++;
            if (out2 !== exp[17-i]) begin
                fails++;
                $display("FAIL near_miss[%0d] out=%b exp=%b", i, out2, exp[17-i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] syms = 18'b01_10_11_11_01_10_11_00_00;
        logic [8:0]  exp  = 9'b001100110;
        for (int i = 0; i < 9; i++) begin
            step(syms[2*(8-i) +: 2]);
            tests++;
            if (out2 !== exp[8-i]) begin
                fails++;
                $display("FAIL back_to_back[%0d] out=%b exp=%b", i, out2, exp[8-i]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(2'b01);
        step(2'b10);
        step(2'b11);
        tests++;
        if (out2 !== 1'b1) begin
            fails++;
            $display("FAIL async_pre out=%b exp=1", out2);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (out2 !== 1'b0) begin
            fails++;
            $display("FAIL async_drop out=%b exp=0", out2);
        end
        rst = 1'b0;
        begin
            logic [13:0] syms = 14'b11_10_11_01_10_11_00;
            logic [6:0]  exp  = 7'b0000011;
            for (int i = 0; i < 7; i++) begin
                step(syms[2*(6-i) +: 2]);
                tests++;
                if (out2 !== exp[6-i]) begin
                    fails++;
                    $display("FAIL async_after[%0d] out=%b exp=%b", i, out2, exp[6-i]);
                end
            end
        end
        step(2'b00);
    endtask

    task automatic test_sweep();
        logic [17:0] syms = 18'b01_10_11_00_00_00_00_00_00;
        logic [8:0]  exp1 = 9'b001000000;
        logic [8:0]  exp5 = 9'b001111100;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            step(syms[2*(8-i) +: 2]);
            tests++;
            if (out1 !== exp1[8-i]) begin
                fails++;
                $display("FAIL sweep_h1[%0d] out=%b exp=%b", i, out1, exp1[8-i]);
            end
            tests++;
            if (out5 !== exp5[8-i]) begin
                fails++;
                $display("FAIL sweep_h5[%0d] out=%b exp=%b", i, out5, exp5[8-i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_near_miss();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
